// File: rtl/hdl_lib_pkg.sv
// Shared library package: tagged-value layout helper and pipeline depth limit.
// A tagged value is {valid, payload}, with the valid bit directly above the payload.
package hdl_lib;

    localparam int MAX_PIPE_STAGES = 8;

    // Bit index of the valid tag inside a tagged value with the given payload width.
    function automatic int tag_valid_idx(input int payload_w);
        return payload_w;
    endfunction

endpackage

// File: rtl/data_pipe_stage.sv
// One pipeline stage: a valid bit plus payload register that loads from upstream
// whenever it is allowed to, and self-clears its payload whenever it ends up empty.
module data_pipe_stage
    import hdl_lib::*;
#(
    parameter int InBitWidth = 32
) (
    input  logic                  clk,
    input  logic                  clear_i,
    input  logic                  load_i,
    input  logic                  src_valid_i,
    input  logic [InBitWidth-1:0] src_data_i,
    output logic                  valid_o,
    output logic [InBitWidth-1:0] data_o
);

    logic                  valid_q;
    logic                  valid_d;
    logic [InBitWidth-1:0] data_q;
    logic [InBitWidth-1:0] data_d;

    // Next-state: clear wins, otherwise take upstream (zeroed if a bubble), else hold.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clear_i) begin
            valid_d = 1'b0;
            data_d  = {InBitWidth{1'b0}};
        end else if (load_i) begin
            valid_d = src_valid_i;
            data_d  = src_valid_i ? src_data_i : {InBitWidth{1'b0}};
        end else begin
            valid_d = valid_q;
            data_d  = data_q;
        end
    end

    // Stage register.
    always_ff @(posedge clk) begin
        valid_q <= valid_d;
        data_q  <= data_d;
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/data_pipe.sv
// Elastic register pipeline for tagged values: bubbles collapse, full-throughput
// handshake, flush and synchronous reset clear every stage.
module data_pipe
    import hdl_lib::*;
#(
    parameter int ParamStages = 2,
    parameter int InBitWidth  = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [InBitWidth:0] in_data,
    output logic                in_ready,
    output logic [InBitWidth:0] out_data,
    input  logic                out_ready,
    input  logic                flush,
    output logic [3:0]          occupancy
);

    localparam int VldIdx = tag_valid_idx(InBitWidth);
    localparam int Last   = ParamStages - 1;

    if (ParamStages < 1 || ParamStages > MAX_PIPE_STAGES) begin : g_bad_param
        $error("data_pipe: ParamStages out of range 1..8");
    end

    logic                  stg_valid_s [ParamStages];
    logic [InBitWidth-1:0] stg_data_s  [ParamStages];
    logic [ParamStages-1:0] load_s;
    logic                  clear_s;
    logic                  in_xfer_s;
    logic                  out_xfer_s;
    logic [3:0]            occ_q;
    logic [3:0]            occ_d;

    assign clear_s = reset | flush;

    // Ready chain walked from the output end: a stage may load if it is empty
    // or the stage after it may load (which is exactly "this stage advances").
    always_comb begin
        logic downstream_load;
        load_s          = {ParamStages{1'b0}};
        downstream_load = out_ready;
        for (int k = Last; k >= 0; k--) begin
            load_s[k]       = ~stg_valid_s[k] | downstream_load;
            downstream_load = load_s[k];
        end
    end

    for (genvar k = 0; k < ParamStages; k++) begin : g_stage
        logic                  src_valid_s;
        logic [InBitWidth-1:0] src_data_s;

        if (k == 0) begin : g_head
            assign src_valid_s = in_data[VldIdx];
            assign src_data_s  = in_data[InBitWidth-1:0];
        end else begin : g_body
            assign src_valid_s = stg_valid_s[k-1];
            assign src_data_s  = stg_data_s[k-1];
        end

        data_pipe_stage #(
            .InBitWidth (InBitWidth)
        ) u_stage (
            .clk         (clk),
            .clear_i     (clear_s),
            .load_i      (load_s[k]),
            .src_valid_i (src_valid_s),
            .src_data_i  (src_data_s),
            .valid_o     (stg_valid_s[k]),
            .data_o      (stg_data_s[k])
        );
    end

    assign in_ready   = load_s[0] & ~flush;
    assign in_xfer_s  = in_data[VldIdx] & in_ready;
    assign out_xfer_s = stg_valid_s[Last] & out_ready;

    // Occupancy tracks accepted minus consumed values; cleared with the stages.
    always_comb begin
        occ_d = occ_q;
        if (clear_s) begin
            occ_d = 4'd0;
        end else if (in_xfer_s && !out_xfer_s) begin
            occ_d = occ_q + 4'd1;
        end else if (!in_xfer_s && out_xfer_s) begin
            occ_d = occ_q - 4'd1;
        end else begin
            occ_d = occ_q;
        end
    end

    // Occupancy register.
    always_ff @(posedge clk) begin
        occ_q <= occ_d;
    end

    assign occupancy = occ_q;
    assign out_data  = {stg_valid_s[Last], stg_data_s[Last]};

endmodule

// File: doc/data_pipe.md
DATA_PIPE -- requirements
Module: data_pipe

Interface
REQ-001 The block SHALL have parameter ParamStages, default 2, meaning number of register stages (legal 1..8).
REQ-002 The block SHALL have parameter InBitWidth, default 32, meaning payload width excluding the valid tag.
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, meaning reset, synchronous and active-high.
REQ-005 The block SHALL have port in_data, input, InBitWidth+1, meaning tagged value: bit InBitWidth is valid, bits InBitWidth-1:0 are payload.
REQ-006 The block SHALL have port in_ready, output, 1, meaning the stage-0 register can accept in_data this cycle.
REQ-007 The block SHALL have port out_data, output, InBitWidth+1, meaning the tagged value of the last stage, in the same format; it connects directly to one DataMux inputN.
REQ-008 The block SHALL have port out_ready, input, 1, meaning the consumer takes out_data this cycle.
REQ-009 The block SHALL have port flush, input, 1, meaning discard all held values.
REQ-010 The block SHALL have port occupancy, output, 4, meaning the count of valid stages.

Function
REQ-011 Each stage SHALL hold one valid bit and one payload register; stage 0 is the input end and stage ParamStages-1 drives out_data.
REQ-012 Transfers SHALL follow these handshake rules:
- Input transfer occurs when in_data valid=1 and in_ready=1.
- Output transfer occurs when out_data valid=1 and out_ready=1.
REQ-013 Stage k SHALL advance when:
- it holds a value and stage k+1 is empty or itself advancing; or
- k is the last stage and out_ready=1.
REQ-014 Stage k SHALL load from stage k-1 (or from in_data for k=0) when stage k is empty or advancing; bubbles collapse so that empty stages never block upstream.
REQ-015 in_ready SHALL equal (stage 0 empty OR stage 0 advancing) AND NOT flush; the ready chain is combinational from out_ready.
REQ-016 Latency SHALL be ParamStages cycles from an input transfer to out_data valid, with no stall.
REQ-017 Throughput SHALL be one value per cycle while out_ready=1.
REQ-018 Values SHALL leave in acceptance order, never duplicated, never dropped except by flush.
REQ-019 out_data payload bits SHALL be zero whenever out_data valid=0.
REQ-020 A stage that is empty SHALL clear its payload register to zero.
REQ-021 When all stages are full and out_ready=0, no stage SHALL change and in_ready SHALL be 0.
REQ-022 flush=1 SHALL clear every valid bit and payload at the next edge, and the input presented in the same cycle SHALL be dropped.
REQ-023 During a flush cycle out_data SHALL still show the current last stage; any out_ready handshake in that cycle counts as consumed.
REQ-024 occupancy SHALL be the registered-state count of valid stages, range 0..ParamStages, updated in the same cycle as the stage registers.

Reset
REQ-025 reset=1 SHALL at the next clk edge clear all valid bits and payloads, so that out_data=0 and occupancy=0; in_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-026 reset SHALL take precedence over flush and over any handshake in the same cycle.
REQ-027 An assertion of reset mid-stream SHALL discard all in-flight values with no partial output.

Structure
REQ-028 The tagged-value helper (valid-bit index = InBitWidth) and the ParamStages legal maximum of 8 SHALL live in the shared hdl_lib package.
REQ-029 One sub-module, data_pipe_stage (a single stage register with load/advance logic), SHALL be instantiated ParamStages times via generate.

Verification
REQ-030 Basic latency: ParamStages=2, out_ready=1; send 0x11,0x22,0x33 back-to-back -> out_data valid with 0x11,0x22,0x33 on cycles 2,3,4.
REQ-031 Stall and recovery: ParamStages=3; fill with 0xA1..0xA3 while out_ready=0 -> occupancy=3, in_ready=0; then raise out_ready -> values exit in order, in_ready=1 on the same cycle.
REQ-032 Bubble collapse: ParamStages=4; feed a single 0x55 with out_ready=0 -> 0x55 reaches the last stage after 4 cycles, occupancy=1, in_ready stays 1.
REQ-033 Flush: occupancy=2, pulse flush while in_data=0x1_00000077 -> next cycle occupancy=0, out_data=0, and 0x77 never appears.
REQ-034 Reset mid-stream: with reset and flush both high while holding 0x99 -> out_data=0 and occupancy=0 next cycle; after deassertion in_ready=1.
REQ-035 DataMux integration: two data_pipe instances feed DataMux input0/input1 with alternating valids (0x0F, then 0xF0) -> DataMux ret shows 0x0F then 0xF0, never an OR of both.
